// File: rtl/hpdmc_dqs_wctl.sv
// DQS/DQ write-path sequencer for a DDR memory controller: turns each accepted
// write into optional write latency, a DQS preamble, a DQS toggle burst and a postamble.

module hpdmc_dqs_lane (
  input  logic gclk,
  input  logic grst_n,
  input  logic nxt_t,
  input  logic nxt_i,
  output logic dqs_t,
  output logic dqs_i
);
  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      dqs_t <= 1'b1;
      dqs_i <= 1'b0;
    end else begin
      dqs_t <= nxt_t;
      dqs_i <= nxt_i;
    end
  end
endmodule

module hpdmc_dqs_wctl #(
  parameter int WR_LAT    = 1,
  parameter int BURST_LEN = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       write,
  output logic       ready,
  output logic [1:0] dqs_t,
  output logic [1:0] dqs_i,
  output logic       dq_t,
  output logic       busy,
  output logic       wr_ovf
);
  localparam int NUM_LANES = 2;
  localparam int BW        = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {IDLE, WAIT, PRE, BURST, POST} state_t;

  state_t        state, nxt_state;
  logic [2:0]    wcnt, nxt_wcnt;
  logic [BW-1:0] bcnt, nxt_bcnt;
  logic          chain, nxt_chain;
  logic          accept;
  logic          nxt_dqs_t, nxt_dqs_i, nxt_dq_t, nxt_busy, nxt_ready;

  assign accept = write & ready;

  always_comb begin
    nxt_state = state;
    nxt_wcnt  = wcnt;
    nxt_bcnt  = bcnt;
    nxt_chain = chain;
    case (state)
      IDLE, POST: begin
        if (accept) begin
          // a write taken in POST keeps DQS driven through the next WAIT
          nxt_chain = (state == POST);
          if (WR_LAT > 0) begin
            nxt_state = WAIT;
            nxt_wcnt  = 3'(WR_LAT);
          end else begin
            nxt_state = PRE;
          end
        end else if (state == POST) begin
          nxt_state = IDLE;
        end
      end
      WAIT: begin
        if (wcnt != 3'd0) nxt_wcnt = wcnt - 3'd1;
        if (wcnt <= 3'd1) nxt_state = PRE;
      end
      PRE: begin
        nxt_state = BURST;
        nxt_bcnt  = BW'(BURST_LEN);
      end
      BURST: begin
        if (bcnt != '0) nxt_bcnt = bcnt - BW'(1);
        if (bcnt <= BW'(1)) nxt_state = POST;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    nxt_busy  = (nxt_state != IDLE);
    nxt_ready = (nxt_state == IDLE) || (nxt_state == POST);
    nxt_dq_t  = (nxt_state != BURST);
    nxt_dqs_t = (nxt_state == IDLE) || (nxt_state == WAIT && !nxt_chain);
    nxt_dqs_i = (nxt_state == BURST) && ((state != BURST) || !dqs_i[0]);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      wcnt   <= '0;
      bcnt   <= '0;
      chain  <= 1'b0;
      dq_t   <= 1'b1;
      busy   <= 1'b0;
      ready  <= 1'b1;
      wr_ovf <= 1'b0;
    end else begin
      state  <= nxt_state;
      wcnt   <= nxt_wcnt;
      bcnt   <= nxt_bcnt;
      chain  <= nxt_chain;
      dq_t   <= nxt_dq_t;
      busy   <= nxt_busy;
      ready  <= nxt_ready;
      wr_ovf <= wr_ovf | (write & ~ready);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    hpdmc_dqs_lane u_lane (
      .gclk   (sys_clk),
      .grst_n (sys_rst_n),
      .nxt_t  (nxt_dqs_t),
      .nxt_i  (nxt_dqs_i),
      .dqs_t  (dqs_t[g]),
      .dqs_i  (dqs_i[g])
    );
  end
endmodule

// File: tb/tb_hpdmc_dqs_wctl.sv
// Scoreboard bench for hpdmc_dqs_wctl: three parameterizations share clock/reset,
// one is driven at a time and its per-cycle outputs are checked against queued expectations.

module tb_hpdmc_dqs_wctl;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       write = 1'b0;
  int         sel = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cnum = 0;

  logic       ready_a [3];
  logic       dqt_a   [3];
  logic       busy_a  [3];
  logic       ovf_a   [3];
  logic [1:0] dqst_a  [3];
  logic [1:0] dqsi_a  [3];
  logic [6:0] obs;
  logic [6:0] exp_q [$];

  always #5 sys_clk = ~sys_clk;

  hpdmc_dqs_wctl #(.WR_LAT(1), .BURST_LEN(4)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .write(write && sel == 0),
    .ready(ready_a[0]), .dqs_t(dqst_a[0]), .dqs_i(dqsi_a[0]), .dq_t(dqt_a[0]),
    .busy(busy_a[0]), .wr_ovf(ovf_a[0]));

  hpdmc_dqs_wctl #(.WR_LAT(0), .BURST_LEN(4)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .write(write && sel == 1),
    .ready(ready_a[1]), .dqs_t(dqst_a[1]), .dqs_i(dqsi_a[1]), .dq_t(dqt_a[1]),
    .busy(busy_a[1]), .wr_ovf(ovf_a[1]));

  hpdmc_dqs_wctl #(.WR_LAT(7), .BURST_LEN(16)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .write(write && sel == 2),
    .ready(ready_a[2]), .dqs_t(dqst_a[2]), .dqs_i(dqsi_a[2]), .dq_t(dqt_a[2]),
    .busy(busy_a[2]), .wr_ovf(ovf_a[2]));

  // {busy, ready, dq_t, dqs_t[1:0], dqs_i[1:0]}
  assign obs = {busy_a[sel], ready_a[sel], dqt_a[sel], dqst_a[sel], dqsi_a[sel]};

  localparam logic [6:0] V_IDLE = 7'b011_11_00;
  localparam logic [6:0] V_PRE  = 7'b101_00_00;
  localparam logic [6:0] V_POST = 7'b111_00_00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle trace following one accepted write.
  task automatic push_trace(input int lat, input int blen, input bit chained, input bit idle);
    for (int i = 0; i < lat; i++) exp_q.push_back(chained ? 7'b101_00_00 : 7'b101_11_00);
    exp_q.push_back(V_PRE);
    for (int k = 0; k < blen; k++) exp_q.push_back((k % 2 == 0) ? 7'b100_00_11 : 7'b100_00_00);
    exp_q.push_back(V_POST);
    if (idle) exp_q.push_back(V_IDLE);
  endtask

  task automatic cyc(input logic w, input string tag);
    logic [6:0] e;
    write = w;
    @(posedge sys_clk);
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 7'bx;
    chk($sformatf("%s[%0d]", tag, cnum), {25'd0, obs}, {25'd0, e});
    cnum++;
  endtask

  initial begin
    write = 1'b1;  // must be ignored while in reset
    repeat (3) @(posedge sys_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk($sformatf("rst_out%0d", k), {25'd0, obs}, {25'd0, V_IDLE});
      chk($sformatf("rst_ovf%0d", k), {31'd0, ovf_a[k]}, 32'd0);
    end
    sys_rst_n = 1'b1;
    write = 1'b0;
    sel = 0;

    // single burst, WR_LAT=1
    push_trace(1, 4, 0, 1);
    cyc(1, "single");
    repeat (7) cyc(0, "single");

    // chained burst: second write accepted in POST
    push_trace(1, 4, 0, 0);
    cyc(1, "chain_a");
    repeat (6) cyc(0, "chain_a");
    push_trace(1, 4, 1, 1);
    cyc(1, "chain_b");
    repeat (7) cyc(0, "chain_b");
    chk("ovf_clean", {31'd0, ovf_a[0]}, 32'd0);

    // write held during BURST is ignored and flagged
    push_trace(1, 4, 0, 1);
    cyc(1, "ovf");
    cyc(0, "ovf");
    cyc(0, "ovf");
    chk("ovf_pre", {31'd0, ovf_a[0]}, 32'd0);
    cyc(1, "ovf");
    chk("ovf_set", {31'd0, ovf_a[0]}, 32'd1);
    cyc(1, "ovf");
    repeat (3) cyc(0, "ovf");
    chk("ovf_sticky", {31'd0, ovf_a[0]}, 32'd1);

    // reset on the second BURST cycle
    push_trace(1, 4, 0, 1);
    cyc(1, "rst_mid");
    repeat (3) cyc(0, "rst_mid");
    exp_q.delete();
    exp_q.push_back(V_IDLE);
    sys_rst_n = 1'b0;
    cyc(1, "rst_hit");
    chk("rst_ovf_clr", {31'd0, ovf_a[0]}, 32'd0);
    sys_rst_n = 1'b1;
    push_trace(1, 4, 0, 1);
    cyc(1, "post_rst");
    repeat (7) cyc(0, "post_rst");
    chk("post_rst_ovf", {31'd0, ovf_a[0]}, 32'd0);

    // WR_LAT=0, single then chained
    sel = 1;
    push_trace(0, 4, 0, 0);
    cyc(1, "lat0_a");
    repeat (5) cyc(0, "lat0_a");
    push_trace(0, 4, 1, 1);
    cyc(1, "lat0_b");
    repeat (6) cyc(0, "lat0_b");

    // WR_LAT=7, BURST_LEN=16
    sel = 2;
    push_trace(7, 16, 0, 1);
    cyc(1, "long");
    repeat (25) cyc(0, "long");
    chk("long_ovf", {31'd0, ovf_a[2]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
